btn_debounce_sched: RTL
=======================

# btn_debounce_sched

Time-multiplexed debouncer and event scheduler for the board push-buttons. One shared stability counter serves N buttons, granted round-robin to whichever button's synchronized level disagrees with its debounced level. Confirmed changes update a debounced level vector and are queued as press/release events on a valid/ready port for the camera-control logic.

## Interface
- `N_BTN`, default 4: number of buttons, 2..16.
- `STABLE_CYCLES`, default 1000000: consecutive agreeing samples required to confirm a change, at least 2.
- `CNT_W`, default 20: stability counter width; must satisfy 2^CNT_W ≥ STABLE_CYCLES.
- `clk`, input, 1: system clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `btn_raw`, input, N_BTN: raw button pins, asynchronous, active-high.
- `btn_level`, output, N_BTN: debounced levels; reset 0.
- `evt_valid`, output, 1: event pending; reset 0.
- `evt_idx`, output, clog2(N_BTN): button index of the event; reset 0.
- `evt_press`, output, 1: 1 = press (0→1), 0 = release; reset 0.
- `evt_ready`, input, 1: consumer accepts the event when high with `evt_valid`.

## Operation
- `btn_raw` passes through a 2-flop synchronizer, giving `sync`, which is reset to 0. Only `sync` is used downstream.
- `mismatch[i] = sync[i] ^ btn_level[i]`.
- `rr_ptr` holds the last granted index and resets to N_BTN-1.
- FSM states:
  - **IDLE.** If any `mismatch` bit is set, grant the first set index searching `rr_ptr+1`, `rr_ptr+2`, … modulo N_BTN. Latch `own <= idx`, `target <= sync[idx]`, `rr_ptr <= idx`, `cnt <= 0`, then go to COUNT. Otherwise stay in IDLE.
  - **COUNT.** Each cycle:
    - If `sync[own] != target`, abort: go to IDLE; `btn_level` and outputs are unchanged.
    - Else if `cnt < STABLE_CYCLES-1`, set `cnt <= cnt+1`.
    - Else (`cnt == STABLE_CYCLES-1`): if the output slot is free (`!evt_valid || evt_ready`), commit: `btn_level[own] <= target`, `evt_valid <= 1`, `evt_idx <= own`, `evt_press <= target`, then go to IDLE. If the slot is busy, hold `cnt` and stay in COUNT, still monitoring stability; a bounce while waiting aborts.
- Output slot is one entry. `evt_valid` clears on a cycle with `evt_ready` unless a commit loads a new event on that same edge. Simultaneous accept and commit is allowed and gives back-to-back events.
- `evt_idx` and `evt_press` are stable while `evt_valid && !evt_ready`.
- Other buttons' mismatches are ignored while COUNT is active; they are served in later IDLE scans. Round-robin prevents starvation.

## Timing
- Synchronizer latency: 2 cycles from a `btn_raw` edge to `sync`.
- Uncontended confirm: a mismatch visible in IDLE at edge E gives COUNT at E+1. Commit happens at edge E+STABLE_CYCLES, where `btn_level` and `evt_valid` rise together.
- Total delay from raw edge to `btn_level`: STABLE_CYCLES+2 cycles, plus at most one IDLE cycle.
- After commit or abort, at least one IDLE cycle occurs before the next grant.
- Counter never wraps: it saturates at STABLE_CYCLES-1 while waiting.
- Reset asserted mid-operation clears the FSM, `cnt`, synchronizer, `btn_level`, and any pending event immediately (event lost). The first grant after release goes to index 0.

## Structure
- Package `btn_pkg`:
  - FSM state enum (IDLE, COUNT).
  - Index width function `clog2`.
- Sub-module `btn_sync`: N-wide 2-flop synchronizer with asynchronous reset, instantiated once.
- The round-robin search is a combinational function inside the main module.

## Test plan
All scenarios use N_BTN=4, STABLE_CYCLES=8, CNT_W=4, `evt_ready=1` unless noted.
- Clean press on btn 2, held: `btn_level=4'b0100` and a single `evt_valid` pulse with `evt_idx=2`, `evt_press=1`, 10 cycles after the raw edge (+1 for the IDLE scan). Release gives `evt_press=0`.
- Btn 1 bounces: high 5 cycles, low 3 cycles, then stable high. No event from the first burst; exactly one press event after stable high for 8 counted cycles.
- Btns 0 and 3 rise on the same cycle: btn 0 event first, btn 3 event at least 9 cycles later. Next contention with `rr_ptr=0` grants btn 3 first.
- `evt_ready=0`, btn 0 pressed, then btn 1 pressed: first event held stable. Btn 1 waits in COUNT with `cnt=7`, committing on the cycle `evt_ready` rises. Two consecutive valid events with no gap.
- `rst` pulsed while COUNT is active at `cnt=5` and an event is pending: all outputs 0 within the reset cycle. After release with the button still held, a fresh press event appears after a full confirm.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer/scheduler.
package btn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    // Index width for n buttons (n >= 2).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// N-wide two-flop synchronizer for asynchronous button pins.
module btn_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce_sched.sv
// Debouncer sharing one stability counter across all buttons, granted round-robin,
// with confirmed level changes delivered as press/release events on a one-entry slot.
module btn_debounce_sched
    import btn_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_BTN-1:0]        btn_raw,
    output logic [N_BTN-1:0]        btn_level,
    output logic                    evt_valid,
    output logic [clog2(N_BTN)-1:0] evt_idx,
    output logic                    evt_press,
    input  logic                    evt_ready
);

    localparam int               IW      = clog2(N_BTN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [N_BTN-1:0] sync;
    logic [N_BTN-1:0] mismatch;
    logic [IW-1:0]    pick;
    logic             slot_free;

    state_e           state_q, state_d;
    logic [IW-1:0]    own_q, own_d;
    logic             target_q, target_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IW-1:0]    evt_idx_q, evt_idx_d;
    logic             evt_press_q, evt_press_d;

    btn_sync #(.W(N_BTN)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_raw),
        .q_o (sync)
    );

    // First set bit of m searching ptr+1, ptr+2, ... modulo N_BTN.
    function automatic logic [IW-1:0] rr_pick(input logic [N_BTN-1:0] m,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] r;
        logic          found;
        int            j;
        r     = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_BTN; k++) begin
            j = int'(ptr) + k;
            if (j >= N_BTN) j = j - N_BTN;
            if (!found && m[j]) begin
                r     = IW'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign mismatch  = sync ^ level_q;
    assign pick      = rr_pick(mismatch, rr_q);
    assign slot_free = !evt_valid_q || evt_ready;

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        target_d    = target_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        evt_valid_d = evt_valid_q && !evt_ready;
        evt_idx_d   = evt_idx_q;
        evt_press_d = evt_press_q;
        case (state_q)
            IDLE: begin
                if (|mismatch) begin
                    own_d    = pick;
                    target_d = sync[pick];
                    rr_d     = pick;
                    cnt_d    = '0;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (sync[own_q] != target_q) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (slot_free) begin
                    // A commit may overwrite an event being accepted on this same edge.
                    level_d[own_q] = target_q;
                    evt_valid_d    = 1'b1;
                    evt_idx_d      = own_q;
                    evt_press_d    = target_q;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            own_q       <= '0;
            target_q    <= 1'b0;
            rr_q        <= IW'(N_BTN - 1);
            cnt_q       <= '0;
            level_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            evt_press_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            target_q    <= target_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            evt_press_q <= evt_press_d;
        end
    end

    assign btn_level = level_q;
    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign evt_press = evt_press_q;

endmodule
